// File: rtl/edf_grant_scheduler_if.sv
// edf_grant_scheduler_if: request/grant bundle between requesters, the EDF scheduler and the downstream selector.
//  req_valid/req_ready   per-requester request handshake
//  cfg_deadline          relative deadline per requester, in cycles
//  grant_valid/ready     winner handshake with the downstream consumer
//  grant_index           winner index, drives the selector tree
//  grant_deadline        winner's remaining deadline at selection
//  deadline_miss         per-requester one-cycle miss pulse
interface edf_grant_scheduler_if #(
    parameter int INPUTS        = 8,
    parameter int DEADLINE_SIZE = 16
);
    localparam int IW = $clog2(INPUTS);
    logic [INPUTS-1:0]                    req_valid;
    logic [INPUTS-1:0]                    req_ready;
    logic [INPUTS-1:0][DEADLINE_SIZE-1:0] cfg_deadline;
    logic                                 grant_valid;
    logic                                 grant_ready;
    logic [IW-1:0]                        grant_index;
    logic [DEADLINE_SIZE-1:0]             grant_deadline;
    logic [INPUTS-1:0]                    deadline_miss;
    modport master (
        output req_valid, cfg_deadline, grant_ready,
        input  req_ready, grant_valid, grant_index, grant_deadline, deadline_miss
    );
    modport slave (
        input  req_valid, cfg_deadline, grant_ready,
        output req_ready, grant_valid, grant_index, grant_deadline, deadline_miss
    );
endinterface

// File: rtl/edf_grant_scheduler.sv
// edf_grant_scheduler: earliest-deadline-first arbiter over INPUTS requesters.
//  clock  rising-edge clock
//  reset  synchronous active-high reset
//  bus    slave side of edf_grant_scheduler_if (requests in, grant out)
module edf_grant_scheduler #(
    parameter int INPUTS        = 8,
    parameter int DEADLINE_SIZE = 16
) (
    input logic                  clock,
    input logic                  reset,
    edf_grant_scheduler_if.slave bus
);
    localparam int IW = $clog2(INPUTS);
    typedef enum logic [1:0] {IDLE, COMPARE, GRANT} state_t;
    state_t                               state_q, state_d;
    logic [INPUTS-1:0]                    pending_q, pending_d;
    logic [INPUTS-1:0][DEADLINE_SIZE-1:0] remaining_q, remaining_d;
    logic [INPUTS-1:0]                    miss_q, miss_d;
    logic [IW-1:0]                        winner_q, winner_d;
    logic [DEADLINE_SIZE-1:0]             deadline_q, deadline_d;
    logic [IW-1:0]                        best;
    logic                                 found;
    logic                                 handshake;
    logic                                 accept;
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        remaining_d = remaining_q;
        miss_d      = '0;
        winner_d    = winner_q;
        deadline_d  = deadline_q;
        best        = '0;
        found       = 1'b0;
        accept      = 1'b0;
        handshake   = state_q == GRANT && bus.grant_ready;
        for (int i = 0; i < INPUTS; i++) begin
            accept = bus.req_valid[i] && !pending_q[i];
            // Miss is flagged on the edge the counter lands on 0, so it is visible in the cycle it reads 0.
            miss_d[i] = accept ? bus.cfg_deadline[i] == '0
                               : pending_q[i] && remaining_q[i] == DEADLINE_SIZE'(1);
            if (pending_q[i] && remaining_q[i] != '0)
                remaining_d[i] = remaining_q[i] - DEADLINE_SIZE'(1);
            if (handshake && winner_q == IW'(i))
                pending_d[i] = 1'b0;
            if (accept) begin
                pending_d[i]   = 1'b1;
                remaining_d[i] = bus.cfg_deadline[i];
            end
            // Strict less-than keeps the lowest index on ties.
            if (pending_q[i] && (!found || remaining_q[i] < remaining_q[best])) begin
                best  = IW'(i);
                found = 1'b1;
            end
        end
        unique case (state_q)
            IDLE:    state_d = |pending_q ? COMPARE : IDLE;
            COMPARE: begin
                winner_d   = best;
                // Latch the winner's counter as it stands after this edge; it keeps counting during GRANT.
                deadline_d = remaining_d[best];
                state_d    = GRANT;
            end
            GRANT:   state_d = handshake ? (|pending_d ? COMPARE : IDLE) : GRANT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            remaining_q <= '0;
            miss_q      <= '0;
            winner_q    <= '0;
            deadline_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
            miss_q      <= miss_d;
            winner_q    <= winner_d;
            deadline_q  <= deadline_d;
        end
    end
    assign bus.req_ready      = ~pending_q;
    assign bus.grant_valid    = state_q == GRANT;
    assign bus.grant_index    = winner_q;
    assign bus.grant_deadline = deadline_q;
    assign bus.deadline_miss  = miss_q;
endmodule

// File: tb/tb_edf_grant_scheduler.sv
// tb_edf_grant_scheduler: directed and random checks of the EDF scheduler against a cycle-level reference model.
module tb_edf_grant_scheduler;
    localparam int N  = 8;
    localparam int DW = 16;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    edf_grant_scheduler_if #(.INPUTS(N), .DEADLINE_SIZE(DW)) bus ();
    edf_grant_scheduler #(.INPUTS(N), .DEADLINE_SIZE(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    logic [N-1:0][DW-1:0] cfg;
    int vectors = 0;
    int miscompares = 0;
    bit m_pend[N];
    int m_rem[N];
    bit m_miss[N];
    int m_win;
    bit m_cmp;
    int m_gdl;
    int gq[$];
    int gt[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_rem[i]  = 0;
            m_miss[i] = 0;
        end
        m_win = -1;
        m_cmp = 0;
        m_gdl = 0;
    endfunction
    function automatic void model_update(input logic [N-1:0] rv, input logic gr);
        bit np[N];
        int nr[N];
        bit hs, acc, any_old, any_new;
        int best;
        hs = m_win >= 0 && gr;
        best = -1;
        any_old = 0;
        any_new = 0;
        for (int i = 0; i < N; i++) begin
            acc = rv[i] && !m_pend[i];
            m_miss[i] = acc ? int'(cfg[i]) == 0 : m_pend[i] && m_rem[i] == 1;
            nr[i] = acc ? int'(cfg[i]) : (m_pend[i] && m_rem[i] > 0 ? m_rem[i] - 1 : m_rem[i]);
            np[i] = acc || (m_pend[i] && !(hs && i == m_win));
            if (m_pend[i] && (best < 0 || m_rem[i] < m_rem[best])) best = i;
            any_old |= m_pend[i];
            any_new |= np[i];
        end
        if (m_cmp) begin
            m_win = best;
            m_gdl = nr[best];
            m_cmp = 0;
        end else if (m_win >= 0) begin
            if (hs) begin
                m_win = -1;
                m_cmp = any_new;
            end
        end else begin
            m_cmp = any_old;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i];
            m_rem[i]  = nr[i];
        end
    endfunction
    task automatic check_model();
        logic [N-1:0] er, em;
        for (int i = 0; i < N; i++) begin
            er[i] = !m_pend[i];
            em[i] = m_miss[i];
        end
        chk("req_ready", bus.req_ready, er);
        chk("deadline_miss", bus.deadline_miss, em);
        chk("grant_valid", bus.grant_valid, m_win >= 0);
        if (m_win >= 0) begin
            chk("grant_index", bus.grant_index, m_win);
            chk("grant_deadline", bus.grant_deadline, m_gdl);
        end
    endtask
    task automatic step(input logic [N-1:0] rv, input logic gr, input logic rs);
        bus.req_valid    = rv;
        bus.grant_ready  = gr;
        bus.cfg_deadline = cfg;
        reset            = rs;
        @(posedge clock);
        if (rs) model_reset();
        else model_update(rv, gr);
        @(negedge clock);
        check_model();
    endtask
    task automatic collect(input int cycles);
        gq.delete();
        gt.delete();
        for (int c = 0; c < cycles; c++) begin
            step('0, 1'b1, 1'b0);
            if (bus.grant_valid) begin
                gq.push_back(int'(bus.grant_index));
                gt.push_back(c);
            end
        end
    endtask
    initial begin
        cfg = '0;
        bus.req_valid = '0;
        bus.grant_ready = 1'b0;
        bus.cfg_deadline = '0;
        model_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        chk("rst_ready", bus.req_ready, 8'hFF);
        chk("rst_valid", bus.grant_valid, 0);
        chk("rst_index", bus.grant_index, 0);
        chk("rst_deadline", bus.grant_deadline, 0);
        chk("rst_miss", bus.deadline_miss, 0);
        // single request
        cfg[3] = 16'd20;
        step(8'h08, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("t1_not_yet", bus.grant_valid, 0);
        step('0, 1'b0, 1'b0);
        chk("t1_valid", bus.grant_valid, 1);
        chk("t1_index", bus.grant_index, 3);
        chk("t1_deadline", bus.grant_deadline, 18);
        chk("t1_ready_low", bus.req_ready[3], 0);
        step('0, 1'b1, 1'b0);
        chk("t1_ready_back", bus.req_ready[3], 1);
        step('0, 1'b0, 1'b1);
        // EDF ordering
        cfg = '0;
        cfg[1] = 16'd50;
        cfg[5] = 16'd10;
        cfg[6] = 16'd30;
        step(8'h62, 1'b1, 1'b0);
        collect(10);
        chk("t2_count", gq.size(), 3);
        chk("t2_first", gq[0], 5);
        chk("t2_second", gq[1], 6);
        chk("t2_third", gq[2], 1);
        chk("t2_gap_a", gt[1] - gt[0], 2);
        chk("t2_gap_b", gt[2] - gt[1], 2);
        step('0, 1'b0, 1'b1);
        // tie on equal deadlines
        cfg = '0;
        cfg[2] = 16'd8;
        cfg[4] = 16'd8;
        step(8'h14, 1'b1, 1'b0);
        collect(8);
        chk("t3_count", gq.size(), 2);
        chk("t3_first", gq[0], 2);
        chk("t3_second", gq[1], 4);
        step('0, 1'b0, 1'b1);
        // deadline miss under backpressure
        cfg = '0;
        cfg[0] = 16'd2;
        step(8'h01, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("t4_no_miss_yet", bus.deadline_miss, 0);
        step('0, 1'b0, 1'b0);
        chk("t4_miss_pulse", bus.deadline_miss, 8'h01);
        chk("t4_valid", bus.grant_valid, 1);
        step('0, 1'b0, 1'b0);
        chk("t4_miss_over", bus.deadline_miss, 0);
        chk("t4_index", bus.grant_index, 0);
        chk("t4_deadline", bus.grant_deadline, 0);
        for (int k = 0; k < 4; k++) step('0, 1'b0, 1'b0);
        chk("t4_no_repulse", bus.deadline_miss, 0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b1);
        // backpressure while a more urgent request arrives
        cfg = '0;
        cfg[0] = 16'd40;
        cfg[7] = 16'd1;
        step(8'h01, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step('0, 1'b0, 1'b0);
        chk("t5_held_index", bus.grant_index, 0);
        chk("t5_held_valid", bus.grant_valid, 1);
        step('0, 1'b1, 1'b0);
        chk("t5_bubble", bus.grant_valid, 0);
        step('0, 1'b0, 1'b0);
        chk("t5_next_index", bus.grant_index, 7);
        chk("t5_next_valid", bus.grant_valid, 1);
        step('0, 1'b1, 1'b0);
        // reset in the middle of a grant
        cfg = '0;
        cfg[1] = 16'd30;
        cfg[2] = 16'd40;
        cfg[3] = 16'd50;
        step(8'h0E, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("t6_in_grant", bus.grant_valid, 1);
        step('0, 1'b0, 1'b1);
        chk("t6_ready", bus.req_ready, 8'hFF);
        chk("t6_valid", bus.grant_valid, 0);
        chk("t6_index", bus.grant_index, 0);
        chk("t6_deadline", bus.grant_deadline, 0);
        for (int k = 0; k < 4; k++) step('0, 1'b1, 1'b0);
        chk("t6_no_grant", bus.grant_valid, 0);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) cfg[i] = DW'($urandom_range(0, 20));
            step(N'($urandom & $urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 149) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
